// File: rtl/sim_halt_monitor.sv
// sim_halt_monitor: run-control monitor that ends a simulation on halt, error drain, timeout or commit starvation.
module sim_halt_monitor #(
  parameter int NCOMMIT        = 1,
  parameter int ERRW           = 16,
  parameter int CNTW           = 32,
  parameter int TIMEOUT_CYCLES = 100000000,
  parameter int IDLE_LIMIT     = 10000,
  parameter int ERR_DRAIN      = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [NCOMMIT-1:0] commit,
  input  logic [NCOMMIT-1:0] halt,
  input  logic [ERRW-1:0]    errcode,
  output logic               done,
  output logic [2:0]         cause,
  output logic [ERRW-1:0]    err_latched,
  output logic [CNTW-1:0]    cycles,
  output logic [CNTW-1:0]    commits
);
  typedef enum logic [1:0] {RUN, DRAIN, FIN} state_t;
  state_t            state_q, state_d;
  logic              done_q, done_d;
  logic [2:0]        cause_q, cause_d;
  logic [ERRW-1:0]   err_q, err_d;
  logic [CNTW-1:0]   cycles_q, cycles_d, commits_q, commits_d, idle_q, idle_d, drain_q, drain_d;
  logic [CNTW:0]     pc, csum;
  always_comb begin
    state_d   = state_q;
    done_d    = done_q;
    cause_d   = cause_q;
    err_d     = err_q;
    cycles_d  = cycles_q;
    commits_d = commits_q;
    idle_d    = idle_q;
    drain_d   = drain_q;
    pc        = '0;
    for (int i = 0; i < NCOMMIT; i++) pc = pc + (CNTW+1)'(commit[i]);
    csum = {1'b0, commits_q} + pc;
    if (en && state_q != FIN) begin
      cycles_d  = &cycles_q ? cycles_q : cycles_q + 1'b1;
      commits_d = csum[CNTW] ? '1 : csum[CNTW-1:0];
      if (state_q == RUN) begin
        idle_d = |commit ? '0 : idle_q + 1'b1;
        if (|errcode) begin
          err_d   = errcode;
          cause_d = 3'd2;
          if (ERR_DRAIN == 0) begin
            state_d = FIN;
            done_d  = 1'b1;
          end else begin
            state_d = DRAIN;
            drain_d = CNTW'(ERR_DRAIN);
          end
        end else if (|(commit & halt)) begin
          state_d = FIN;
          done_d  = 1'b1;
          cause_d = 3'd1;
        end else if (IDLE_LIMIT != 0 && !(|commit) && idle_q == CNTW'(IDLE_LIMIT - 1)) begin
          state_d = FIN;
          done_d  = 1'b1;
          cause_d = 3'd4;
        end else if (TIMEOUT_CYCLES != 0 && cycles_q == CNTW'(TIMEOUT_CYCLES - 1)) begin
          state_d = FIN;
          done_d  = 1'b1;
          cause_d = 3'd3;
        end
      end else begin
        drain_d = drain_q - 1'b1;
        state_d = drain_q == CNTW'(1) ? FIN : DRAIN;
        done_d  = drain_q == CNTW'(1);
      end
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= RUN;
      done_q    <= 1'b0;
      cause_q   <= '0;
      err_q     <= '0;
      cycles_q  <= '0;
      commits_q <= '0;
      idle_q    <= '0;
      drain_q   <= '0;
    end else begin
      state_q   <= state_d;
      done_q    <= done_d;
      cause_q   <= cause_d;
      err_q     <= err_d;
      cycles_q  <= cycles_d;
      commits_q <= commits_d;
      idle_q    <= idle_d;
      drain_q   <= drain_d;
    end
  end
  assign done        = done_q;
  assign cause       = cause_q;
  assign err_latched = err_q;
  assign cycles      = cycles_q;
  assign commits     = commits_q;
endmodule

// File: tb/tb_sim_halt_monitor.sv
// tb_sim_halt_monitor: directed checks of halt, error drain, timeout, deadlock and async reset.
module tb_sim_halt_monitor;
  logic        clk, rst, en;
  logic [1:0]  commit, halt;
  logic [15:0] errcode;
  logic        done_a, done_b;
  logic [2:0]  cause_a, cause_b;
  logic [15:0] err_a, err_b;
  logic [31:0] cyc_a, cyc_b, com_a, com_b;
  int checks = 0, failures = 0;
  typedef struct {bit sel; logic [2:0] cause; logic [15:0] err; logic [31:0] cyc; logic [31:0] com;} exp_t;
  exp_t sb[$];

  sim_halt_monitor #(.NCOMMIT(2), .ERRW(16), .CNTW(32), .TIMEOUT_CYCLES(50), .IDLE_LIMIT(8), .ERR_DRAIN(5)) dut_a (
    .clk(clk), .rst(rst), .en(en), .commit(commit), .halt(halt), .errcode(errcode),
    .done(done_a), .cause(cause_a), .err_latched(err_a), .cycles(cyc_a), .commits(com_a));
  sim_halt_monitor #(.NCOMMIT(2), .ERRW(16), .CNTW(32), .TIMEOUT_CYCLES(0), .IDLE_LIMIT(0), .ERR_DRAIN(0)) dut_b (
    .clk(clk), .rst(rst), .en(en), .commit(commit), .halt(halt), .errcode(errcode),
    .done(done_b), .cause(cause_b), .err_latched(err_b), .cycles(cyc_b), .commits(com_b));

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst = 0; en = 0; commit = 0; halt = 0; errcode = 0;
    #2;
    chk("rst_done", done_a, 0);
    chk("rst_cause", cause_a, 0);
    chk("rst_err", err_a, 0);
    chk("rst_cycles", cyc_a, 0);
    chk("rst_commits", com_a, 0);
    @(posedge clk);
    #1;
    rst = 1;
  endtask

  task automatic push(input bit sel, input logic [2:0] c, input logic [15:0] e, input logic [31:0] cy, input logic [31:0] co);
    exp_t x;
    x.sel = sel; x.cause = c; x.err = e; x.cyc = cy; x.com = co;
    sb.push_back(x);
  endtask

  task automatic expect_end(input string tag);
    exp_t x;
    int n = 0;
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 0, 1);
      return;
    end
    x = sb.pop_front();
    while (!(x.sel ? done_b : done_a) && n < 100) begin
      step();
      n++;
    end
    chk({tag, "_done"}, x.sel ? done_b : done_a, 1);
    chk({tag, "_cause"}, x.sel ? cause_b : cause_a, x.cause);
    chk({tag, "_err"}, x.sel ? err_b : err_a, x.err);
    chk({tag, "_cycles"}, x.sel ? cyc_b : cyc_a, x.cyc);
    chk({tag, "_commits"}, x.sel ? com_b : com_a, x.com);
  endtask

  initial begin
    // halt: two channels commit for 10 cycles, then channel 1 halts
    do_reset();
    en = 1; commit = 2'b11;
    step(10);
    chk("halt_pre_done", done_a, 0);
    halt = 2'b10;
    push(0, 3'd1, 16'h0, 32'd11, 32'd22);
    step();
    chk("halt_latency", done_a, 1);
    expect_end("halt");
    commit = 2'b11; halt = 2'b00;
    step(3);
    chk("halt_frozen_cycles", cyc_a, 11);
    // error at cycle 20, later code ignored, halt during drain ignored
    do_reset();
    en = 1; commit = 2'b01;
    step(20);
    errcode = 16'h0007;
    push(0, 3'd2, 16'h0007, 32'd26, 32'd26);
    step();
    errcode = 16'h0009; halt = 2'b01;
    step();
    halt = 2'b00;
    step(3);
    chk("err_drain_not_done", done_a, 0);
    chk("err_drain_cause", cause_a, 2);
    step();
    chk("err_drain_latency", done_a, 1);
    expect_end("err");
    // timeout with a 10-cycle enable gap
    do_reset();
    en = 1; commit = 2'b01;
    step(25);
    en = 0;
    step(10);
    chk("to_hold_cycles", cyc_a, 25);
    en = 1;
    push(0, 3'd3, 16'h0, 32'd50, 32'd50);
    step(24);
    chk("to_not_done", done_a, 0);
    step();
    chk("to_latency", done_a, 1);
    expect_end("timeout");
    // deadlock: a commit at silent cycle 7 restarts the idle count
    do_reset();
    en = 1; commit = 2'b01;
    step(3);
    commit = 2'b00;
    step(6);
    commit = 2'b10;
    step();
    commit = 2'b00;
    push(0, 3'd4, 16'h0, 32'd18, 32'd4);
    step(7);
    chk("dl_not_done", done_a, 0);
    step();
    chk("dl_latency", done_a, 1);
    expect_end("deadlock");
    // same-cycle error and halt, no drain
    do_reset();
    en = 1; commit = 2'b01; halt = 2'b01; errcode = 16'h0001;
    push(1, 3'd2, 16'h0001, 32'd1, 32'd1);
    step();
    chk("errhalt_latency", done_b, 1);
    expect_end("err_halt");
    // async reset mid-drain, then a halt ends the run
    do_reset();
    en = 1; errcode = 16'h0003;
    step();
    errcode = 16'h0000;
    chk("mid_drain_cause", cause_a, 2);
    #2;
    rst = 0;
    #1;
    chk("async_cause", cause_a, 0);
    chk("async_err", err_a, 0);
    chk("async_cycles", cyc_a, 0);
    do_reset();
    en = 1; commit = 2'b01; halt = 2'b01;
    push(0, 3'd1, 16'h0, 32'd1, 32'd1);
    step();
    expect_end("post_reset_halt");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
